rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter N_STAGES, default 3: number of sequenced reset outputs, legal range 1..8.
REQ-002 SHALL have parameter MIN_ASSERT, default 8: minimum cycles all stage resets stay asserted after a reset source is removed, legal values >= 1.
REQ-003 SHALL have parameter STAGE_DLY, default 4: cycles between successive stage releases, legal values >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sw_rst_req, input, 1 bit: level software-reset request.
REQ-007 SHALL have port sw_rst_ack, output, 1 bit: one-cycle acknowledge of an accepted software reset.
REQ-008 SHALL have port stage_rst, output, N_STAGES bits: active-high per-domain resets; bit 0 is released first.
REQ-009 SHALL have port ready, output, 1 bit: high when all stages are released.
REQ-010 SHALL have port rst_count, output, 8 bits: number of completed release sequences.

Function
REQ-011 SHALL implement an FSM with states HOLD, RELEASE and RUN, plus an internal cycle counter cnt and a stage index idx.
REQ-012 HOLD: all stage_rst bits = 1, ready = 0; cnt increments each cycle; when cnt == MIN_ASSERT-1, next state is RELEASE with cnt = 0 and idx = 0.
REQ-013 RELEASE: cnt increments each cycle; when cnt == STAGE_DLY-1, stage_rst[idx] clears, cnt returns to 0 and idx increments.
REQ-014 Timing of RELEASE: counting edge 1 as the first posedge with rst = 0, stage k SHALL clear at edge MIN_ASSERT + (k+1)*STAGE_DLY.
REQ-015 Exit from RELEASE: the edge that clears stage N_STAGES-1 SHALL also set ready = 1, enter RUN and increment rst_count.
REQ-016 Stage ordering: released stages SHALL stay released, so stage_rst is always a contiguous run of ones at the MSB end (thermometer code).
REQ-017 RUN: when sw_rst_req = 1, the next edge SHALL:
- set sw_rst_ack = 1 for exactly one cycle;
- set all stage_rst bits = 1 and ready = 0;
- set cnt = 0 and enter HOLD.
REQ-018 A sw_rst_req held high after the ack SHALL NOT generate a second ack until the FSM has returned to RUN; it SHALL then be accepted again on the first RUN cycle.
REQ-019 sw_rst_req SHALL be ignored in HOLD and RELEASE: no ack is issued and no timer restarts.
REQ-020 rst_count SHALL saturate at 255, SHALL NOT be cleared by a software reset, and SHALL be cleared only by rst.
REQ-021 rst = 1 SHALL take priority over every other event in every state, including mid-RELEASE and on the same cycle as sw_rst_req.
REQ-022 cnt SHALL be $clog2(max(MIN_ASSERT, STAGE_DLY)+1) bits wide and SHALL never wrap inside a state.

Reset
REQ-023 While rst = 1, the block SHALL hold: state HOLD, cnt = 0, idx = 0, stage_rst all ones, ready = 0, sw_rst_ack = 0, rst_count = 0.
REQ-024 After rst is deasserted, the MIN_ASSERT count SHALL restart from 0, independent of any prior progress.

Structure
REQ-025 State encodings and the parameter defaults SHALL live in shared package rst_seq_pkg.
REQ-026 The cycle timer SHALL be a sub-module rst_seq_cnt (clear, enable, terminal-count compare); the FSM and outputs SHALL stay in rst_seq.
REQ-027 All outputs SHALL be registered.

Verification
REQ-028 Defaults, rst high 3 cycles then low -> stage_rst = 111 through edge 11; 110 at edge 12; 100 at edge 16; 000 and ready = 1 at edge 20; rst_count = 1.
REQ-029 Pulse sw_rst_req for 1 cycle in RUN -> sw_rst_ack high for exactly 1 cycle; stage_rst = 111; release repeats the 12/16/20-cycle timing; rst_count = 2.
REQ-030 Hold sw_rst_req high continuously -> one ack per full sequence, i.e. every 21 cycles; no ack during HOLD or RELEASE.
REQ-031 Assert rst at edge 14 (stage_rst = 110) -> stage_rst = 111, ready = 0 and rst_count = 0 on the next edge; full 20-cycle sequence after release.
REQ-032 rst and sw_rst_req both high in RUN -> rst behaviour only, sw_rst_ack stays 0.
REQ-033 N_STAGES = 1, MIN_ASSERT = 1, STAGE_DLY = 1 -> stage_rst clears and ready rises at edge 2; 300 software resets -> rst_count = 255.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared definitions for the reset sequencer.
//   - parameter defaults (stage count, minimum assert time, stage spacing)
//   - FSM state encoding
//   - cnt_width(): timer width large enough for the longest terminal count
package rst_seq_pkg;

  localparam int N_STAGES_DEF   = 3;
  localparam int MIN_ASSERT_DEF = 8;
  localparam int STAGE_DLY_DEF  = 4;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// rst_seq_if: software-reset handshake and sequenced reset outputs.
//   sw_rst_req : level software-reset request (master -> sequencer)
//   sw_rst_ack : one-cycle acknowledge of an accepted request
//   stage_rst  : active-high per-domain resets, bit 0 released first
//   ready      : all stages released
//   rst_count  : completed release sequences, saturating at 255
interface rst_seq_if
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES = N_STAGES_DEF
);
  logic                sw_rst_req;
  logic                sw_rst_ack;
  logic [N_STAGES-1:0] stage_rst;
  logic                ready;
  logic [7:0]          rst_count;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack, stage_rst, ready, rst_count
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack, stage_rst, ready, rst_count
  );
endinterface

// File: rtl/rst_seq_cnt.sv
// rst_seq_cnt: cycle timer for the reset sequencer.
//   clk, rst   : clock and synchronous active-high reset
//   clr_i      : force the count to zero on the next edge (wins over en_i)
//   en_i       : increment the count on the next edge
//   tc_val_i   : terminal-count value to compare against
//   tc_o       : current count equals tc_val_i
module rst_seq_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == tc_val_i);

endmodule

// File: rtl/rst_seq.sv
// rst_seq: reset sequencer. Holds all stage resets for MIN_ASSERT cycles,
// then releases them one at a time, STAGE_DLY cycles apart, bit 0 first.
// In RUN a software-reset request restarts the whole sequence.
//   clk, rst : clock and synchronous active-high reset
//   bus      : rst_seq_if slave (sw_rst_req in; sw_rst_ack, stage_rst,
//              ready, rst_count out -- all registered)
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int N_STAGES   = N_STAGES_DEF,
  parameter int MIN_ASSERT = MIN_ASSERT_DEF,
  parameter int STAGE_DLY  = STAGE_DLY_DEF
) (
  input  logic      clk,
  input  logic      rst,
  rst_seq_if.slave  bus
);

  localparam int CNT_W = cnt_width(MIN_ASSERT, STAGE_DLY);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  state_e              state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [N_STAGES-1:0] stage_rst_q;
  logic                ready_q;
  logic                ack_q;
  logic [7:0]          rst_count_q;

  logic                cnt_clr;
  logic                cnt_en;
  logic [CNT_W-1:0]    tc_val;
  logic                tc;

  // The timer counts in HOLD and RELEASE and restarts at its terminal count;
  // in RUN it is held at zero so a new HOLD always starts from a clean count.
  always_comb begin
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    tc_val  = CNT_W'(MIN_ASSERT - 1);
    unique case (state_q)
      ST_HOLD: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
      end
      ST_RELEASE: begin
        cnt_en  = 1'b1;
        cnt_clr = tc;
        tc_val  = CNT_W'(STAGE_DLY - 1);
      end
      default: begin
        cnt_clr = 1'b1;
      end
    endcase
  end

  rst_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (cnt_clr),
    .en_i     (cnt_en),
    .tc_val_i (tc_val),
    .tc_o     (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      stage_rst_q <= '1;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      rst_count_q <= 8'd0;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        ST_HOLD: begin
          if (tc) begin
            state_q <= ST_RELEASE;
            idx_q   <= '0;
          end
        end
        ST_RELEASE: begin
          if (tc) begin
            // Shifting in a zero from the LSB keeps the thermometer shape:
            // released stages stay released, ones remain at the MSB end.
            stage_rst_q <= stage_rst_q << 1;
            if (idx_q == IDX_W'(N_STAGES - 1)) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              if (rst_count_q != 8'hFF) begin
                rst_count_q <= rst_count_q + 8'd1;
              end
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.sw_rst_req) begin
            ack_q       <= 1'b1;
            stage_rst_q <= '1;
            ready_q     <= 1'b0;
            state_q     <= ST_HOLD;
          end
        end
        default: begin
          state_q <= ST_HOLD;
        end
      endcase
    end
  end

  assign bus.sw_rst_ack = ack_q;
  assign bus.stage_rst  = stage_rst_q;
  assign bus.ready      = ready_q;
  assign bus.rst_count  = rst_count_q;

endmodule

// File: tb/tb_rst_seq.sv
// tb_rst_seq: bench for rst_seq. Two instances share one clock: A with the
// default parameters, B with N_STAGES=1, MIN_ASSERT=1, STAGE_DLY=1.
// A reference model tracks, per instance, the number of edges since the
// current sequence started and derives the released-stage count from it.
module tb_rst_seq;

  localparam int NA = 3, MA = 8, DA = 4;
  localparam int NB = 1, MB = 1, DB = 1;

  logic clk;
  logic rst_a, rst_b;

  rst_seq_if #(.N_STAGES(NA)) bus_a ();
  rst_seq_if #(.N_STAGES(NB)) bus_b ();

  rst_seq #(.N_STAGES(NA), .MIN_ASSERT(MA), .STAGE_DLY(DA)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  rst_seq #(.N_STAGES(NB), .MIN_ASSERT(MB), .STAGE_DLY(DB)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int e;     // edges since the current sequence started
    bit run;   // all stages released
    bit ack;
    int cnt;
  } mdl_t;

  mdl_t ma, mb;
  int   vectors;
  int   miscompares;

  function automatic mdl_t mstep(mdl_t m, bit r, bit q, int mn, int n, int d);
    mdl_t x;
    x = m;
    x.ack = 1'b0;
    if (r) begin
      x.e = 0; x.run = 1'b0; x.cnt = 0;
    end else if (m.run) begin
      if (q) begin
        x.ack = 1'b1; x.e = 0; x.run = 1'b0;
      end
    end else begin
      x.e = m.e + 1;
      if (x.e == mn + n * d) begin
        x.run = 1'b1;
        if (x.cnt < 255) x.cnt = x.cnt + 1;
      end
    end
    return x;
  endfunction

  // Stage k is released once e reaches mn + (k+1)*d.
  function automatic logic [31:0] exp_stage(int e, int mn, int n, int d);
    int r;
    int mask;
    r = (e < mn) ? 0 : (e - mn) / d;
    if (r > n) r = n;
    mask = (1 << n) - 1;
    return 32'(mask & ~((1 << r) - 1));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic ra, input logic qa, input logic rb, input logic qb);
    @(negedge clk);
    rst_a = ra; bus_a.sw_rst_req = qa;
    rst_b = rb; bus_b.sw_rst_req = qb;
    @(posedge clk);
    ma = mstep(ma, ra, qa, MA, NA, DA);
    mb = mstep(mb, rb, qb, MB, NB, DB);
    #1;
    chk("a_stage", 32'(bus_a.stage_rst),  exp_stage(ma.e, MA, NA, DA));
    chk("a_ready", 32'(bus_a.ready),      32'(ma.run));
    chk("a_ack",   32'(bus_a.sw_rst_ack), 32'(ma.ack));
    chk("a_count", 32'(bus_a.rst_count),  32'(ma.cnt));
    chk("b_stage", 32'(bus_b.stage_rst),  mb.run ? 32'd0 : exp_stage(mb.e, MB, NB, DB));
    chk("b_ready", 32'(bus_b.ready),      32'(mb.run));
    chk("b_ack",   32'(bus_b.sw_rst_ack), 32'(mb.ack));
    chk("b_count", 32'(bus_b.rst_count),  32'(mb.cnt));
  endtask

  initial begin
    int acks;
    vectors = 0; miscompares = 0;
    ma = '{e: 0, run: 1'b0, ack: 1'b0, cnt: 0};
    mb = ma;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.sw_rst_req = 1'b0; bus_b.sw_rst_req = 1'b0;

    // Reset both instances for three cycles.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
    chk("rst_stage_a", 32'(bus_a.stage_rst), 32'h7);
    chk("rst_ready_a", 32'(bus_a.ready), 32'd0);
    chk("rst_count_a", 32'(bus_a.rst_count), 32'd0);

    // Power-on release; B requests software resets back to back from here on.
    for (int i = 1; i <= 21; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 1)  chk("b_e1_stage", 32'(bus_b.stage_rst), 32'd1);
      if (i == 2)  chk("b_e2_ready", 32'(bus_b.ready), 32'd1);
      if (i == 2)  chk("b_e2_stage", 32'(bus_b.stage_rst), 32'd0);
      if (i == 11) chk("a_e11", 32'(bus_a.stage_rst), 32'h7);
      if (i == 12) chk("a_e12", 32'(bus_a.stage_rst), 32'h6);
      if (i == 15) chk("a_e15", 32'(bus_a.stage_rst), 32'h6);
      if (i == 16) chk("a_e16", 32'(bus_a.stage_rst), 32'h4);
      if (i == 19) chk("a_e19_ready", 32'(bus_a.ready), 32'd0);
      if (i == 20) chk("a_e20", 32'(bus_a.stage_rst), 32'h0);
      if (i == 20) chk("a_e20_ready", 32'(bus_a.ready), 32'd1);
      if (i == 20) chk("a_e20_count", 32'(bus_a.rst_count), 32'd1);
    end

    // One-cycle software reset pulse in RUN.
    for (int j = 1; j <= 22; j++) begin
      step(1'b0, (j == 1), 1'b0, 1'b1);
      if (j == 1)  chk("sw_ack", 32'(bus_a.sw_rst_ack), 32'd1);
      if (j == 1)  chk("sw_stage", 32'(bus_a.stage_rst), 32'h7);
      if (j == 2)  chk("sw_ack_end", 32'(bus_a.sw_rst_ack), 32'd0);
      if (j == 12) chk("sw_e11", 32'(bus_a.stage_rst), 32'h7);
      if (j == 13) chk("sw_e12", 32'(bus_a.stage_rst), 32'h6);
      if (j == 17) chk("sw_e16", 32'(bus_a.stage_rst), 32'h4);
      if (j == 21) chk("sw_e20_ready", 32'(bus_a.ready), 32'd1);
      if (j == 21) chk("sw_count", 32'(bus_a.rst_count), 32'd2);
    end

    // Request held high: one ack per 21-cycle sequence.
    acks = 0;
    for (int j = 1; j <= 63; j++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1);
      if (bus_a.sw_rst_ack) begin
        acks++;
        chk("held_ack_pos", 32'(j % 21), 32'd1);
      end
    end
    chk("held_acks", 32'(acks), 32'd3);

    // rst in the middle of RELEASE.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 13; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_e13", 32'(bus_a.stage_rst), 32'h6);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("mid_rst_stage", 32'(bus_a.stage_rst), 32'h7);
    chk("mid_rst_ready", 32'(bus_a.ready), 32'd0);
    chk("mid_rst_count", 32'(bus_a.rst_count), 32'd0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 19) chk("mid_e19_ready", 32'(bus_a.ready), 32'd0);
      if (i == 20) chk("mid_e20_ready", 32'(bus_a.ready), 32'd1);
    end

    // rst and sw_rst_req together in RUN: rst wins, no ack.
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("both_ack", 32'(bus_a.sw_rst_ack), 32'd0);
    chk("both_stage", 32'(bus_a.stage_rst), 32'h7);
    chk("both_count", 32'(bus_a.rst_count), 32'd0);
    for (int i = 1; i <= 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1);

    // Random traffic on A while B keeps requesting until its count saturates.
    for (int i = 0; i < 1000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), 1'b0, 1'b1);
    end
    chk("b_saturate", 32'(bus_b.rst_count), 32'd255);

    // Random traffic on both.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
